// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU (port C) and the DMA/loader (port D).
// CPU has priority; a streak counter forces a DMA grant after MAX_CPU_BURST back-to-back CPU wins.
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | no transaction; arbitrate and latch the winner on any req
//   ACCESS | one cycle driving mem_en (and mem_we for writes)
//   WAIT   | RD_LAT cycles for read data; capture on the final edge
//   ACK    | one-cycle ack to the winner, rdata valid
module dmem_port_arbiter #(
  parameter int ADDR_W        = 13,
  parameter int DATA_W        = 32,
  parameter int RD_LAT        = 1,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int STK_W = $clog2(MAX_CPU_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);
  localparam logic [STK_W-1:0] STK_MAX  = STK_W'(MAX_CPU_BURST);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_ACK} state_t;

  state_t              state, state_nxt;
  logic                any_req;
  logic                grant_dma;
  logic                lat_dma;
  logic                lat_we;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_wdata;
  logic [CNT_W-1:0]    wait_cnt;
  logic [STK_W-1:0]    streak;

  assign any_req   = cpu_req | dma_req;
  assign grant_dma = dma_req & (~cpu_req | (streak == STK_MAX));

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (any_req) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = lat_we ? S_ACK : S_WAIT;
      S_WAIT:   if (wait_cnt == '0) state_nxt = S_ACK;
      S_ACK:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      streak    <= '0;
      lat_dma   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      wait_cnt  <= '0;
      cpu_rdata <= '0;
      dma_rdata <= '0;
    end else begin
      if (state == S_IDLE && any_req) begin
        lat_dma   <= grant_dma;
        lat_we    <= grant_dma ? dma_we    : cpu_we;
        lat_addr  <= grant_dma ? dma_addr  : cpu_addr;
        lat_wdata <= grant_dma ? dma_wdata : cpu_wdata;
        // Streak only grows while the DMA is actually being held off
        if (grant_dma || !dma_req) streak <= '0;
        else if (streak != STK_MAX) streak <= streak + 1'b1;
      end
      if (state == S_ACCESS) wait_cnt <= CNT_LOAD;
      else if (state == S_WAIT && wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
      if (state == S_WAIT && wait_cnt == '0) begin
        if (lat_dma) dma_rdata <= mem_dout;
        else         cpu_rdata <= mem_dout;
      end
    end
  end

  assign mem_en    = (state == S_ACCESS);
  assign mem_we    = (state == S_ACCESS) & lat_we;
  assign mem_addr  = lat_addr;
  assign mem_din   = lat_wdata;
  assign cpu_ack   = (state == S_ACK) & ~lat_dma;
  assign dma_ack   = (state == S_ACK) & lat_dma;
  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: directed vector table, multi-cycle corner sequences,
// an RD_LAT=3 instance, and a randomized run against a transaction-level reference model.
module tb_dmem_port_arbiter;
  localparam int ADDR_W = 13;
  localparam int DATA_W = 32;
  localparam int RD_LAT = 1;
  localparam int MAXB   = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              cpu_req, cpu_we, cpu_ack, cpu_stall;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              dma_req, dma_we, dma_ack;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata, dma_rdata;
  logic              mem_en, mem_we, busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_din, mem_dout;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .MAX_CPU_BURST(MAXB)) u_dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_rdata(dma_rdata), .dma_ack(dma_ack),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .busy(busy)
  );

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (mem_en && mem_we)  mem[mem_addr] <= mem_din;
    if (mem_en && !mem_we) mem_dout <= mem[mem_addr];
  end

  // second instance with a 3-cycle read latency memory
  logic              d3_cpu_req, d3_cpu_we, d3_cpu_ack, d3_cpu_stall;
  logic [ADDR_W-1:0] d3_cpu_addr;
  logic [DATA_W-1:0] d3_cpu_wdata, d3_cpu_rdata;
  logic              d3_dma_req, d3_dma_we, d3_dma_ack;
  logic [ADDR_W-1:0] d3_dma_addr;
  logic [DATA_W-1:0] d3_dma_wdata, d3_dma_rdata;
  logic              d3_mem_en, d3_mem_we, d3_busy;
  logic [ADDR_W-1:0] d3_mem_addr;
  logic [DATA_W-1:0] d3_mem_din, d3_mem_dout;
  logic [DATA_W-1:0] p3_0, p3_1, p3_2;

  dmem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(3), .MAX_CPU_BURST(MAXB)) u_dut3 (
    .clk(clk), .rst(rst),
    .cpu_req(d3_cpu_req), .cpu_we(d3_cpu_we), .cpu_addr(d3_cpu_addr), .cpu_wdata(d3_cpu_wdata),
    .cpu_rdata(d3_cpu_rdata), .cpu_ack(d3_cpu_ack), .cpu_stall(d3_cpu_stall),
    .dma_req(d3_dma_req), .dma_we(d3_dma_we), .dma_addr(d3_dma_addr), .dma_wdata(d3_dma_wdata),
    .dma_rdata(d3_dma_rdata), .dma_ack(d3_dma_ack),
    .mem_en(d3_mem_en), .mem_we(d3_mem_we), .mem_addr(d3_mem_addr), .mem_din(d3_mem_din),
    .mem_dout(d3_mem_dout), .busy(d3_busy)
  );

  logic [DATA_W-1:0] mem3 [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (d3_mem_en && d3_mem_we) mem3[d3_mem_addr] <= d3_mem_din;
    p3_0 <= mem3[d3_mem_addr];
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign d3_mem_dout = p3_2;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 0;
    tick(); tick();
    rst = 1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_cpu_ack", {31'd0, cpu_ack}, 0);
    chk("rst_dma_ack", {31'd0, dma_ack}, 0);
    chk("rst_mem_en", {31'd0, mem_en}, 0);
    chk("rst_mem_we", {31'd0, mem_we}, 0);
    chk("rst_cpu_rdata", cpu_rdata, 0);
    chk("rst_dma_rdata", dma_rdata, 0);
  endtask

  // Single transaction from idle; lat counts edges from the req-sampling edge to the ack cycle.
  task automatic do_single(input bit is_dma, input bit we, input logic [12:0] addr,
                           input logic [31:0] wdata, output int lat, output logic [31:0] rd);
    lat = -1;
    rd  = '0;
    if (is_dma) begin dma_req = 1; dma_we = we; dma_addr = addr; dma_wdata = wdata; end
    else        begin cpu_req = 1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; end
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (is_dma ? dma_ack : cpu_ack) begin
        lat = n;
        rd  = is_dma ? dma_rdata : cpu_rdata;
        chk("other_ack_idle", {31'd0, is_dma ? cpu_ack : dma_ack}, 0);
        if (!is_dma) chk("cpu_stall_at_ack", {31'd0, cpu_stall}, 0);
        break;
      end
      if (!is_dma) chk("cpu_stall_pending", {31'd0, cpu_stall}, 1);
    end
    cpu_req = 0; dma_req = 0;
    tick();
    chk("busy_after_ack", {31'd0, busy}, 0);
  endtask

  typedef struct {
    bit          is_dma;
    bit          we;
    logic [12:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  // reference model state for the random run
  logic [31:0] ref_mem [32];
  bit          ref_ok  [32];

  initial begin
    int          lat;
    logic [31:0] rd;
    byte         got[10];
    byte         exp_order[10];
    int          nack;

    d3_cpu_req = 0; d3_cpu_we = 0; d3_cpu_addr = '0; d3_cpu_wdata = '0;
    d3_dma_req = 0; d3_dma_we = 0; d3_dma_addr = '0; d3_dma_wdata = '0;
    do_reset();

    vecs[0] = '{0, 1, 13'h005, 32'hDEADBEEF, 32'h0,        2};
    vecs[1] = '{0, 0, 13'h005, 32'h0,        32'hDEADBEEF, 3};
    vecs[2] = '{1, 1, 13'h010, 32'h12345678, 32'h0,        2};
    vecs[3] = '{1, 0, 13'h005, 32'h0,        32'hDEADBEEF, 3};
    vecs[4] = '{0, 1, 13'h1FFF, 32'hA5A5A5A5, 32'hDEADBEEF, 2};
    vecs[5] = '{1, 0, 13'h1FFF, 32'h0,       32'hA5A5A5A5, 3};
    vecs[6] = '{0, 1, 13'h000, 32'h00000001, 32'hDEADBEEF, 2};
    vecs[7] = '{0, 0, 13'h010, 32'h0,        32'h12345678, 3};
    for (int i = 0; i < 8; i++) begin
      do_single(vecs[i].is_dma, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rd);
      chk($sformatf("vec%0d_lat", i), lat, vecs[i].exp_lat);
      chk($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
    end

    // DMA program load, then CPU read-back
    for (int a = 0; a < 16; a++) begin
      do_single(1, 1, 13'(a), 32'(a * 3), lat, rd);
      chk($sformatf("load%0d_lat", a), lat, 2);
    end
    do_single(0, 0, 13'h00A, 32'h0, lat, rd);
    chk("load_read_lat", lat, 3);
    chk("load_read_rdata", rd, 32'h0000001E);

    // both requesters held high: starvation limit
    do_reset();
    exp_order = '{"C","C","C","C","D","C","C","C","C","D"};
    got = '{default: 8'h0};
    nack = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 13'h1F0; cpu_wdata = 32'h1;
    dma_req = 1; dma_we = 1; dma_addr = 13'h1F1; dma_wdata = 32'h2;
    for (int n = 0; n < 100 && nack < 10; n++) begin
      tick();
      if (cpu_ack && dma_ack) chk("ack_overlap", 1, 0);
      if (cpu_ack) begin got[nack] = "C"; nack++; end
      else if (dma_ack) begin got[nack] = "D"; nack++; end
    end
    idle_inputs();
    for (int k = 0; k < 10; k++) chk($sformatf("grant%0d", k), {24'd0, got[k]}, {24'd0, exp_order[k]});
    tick(); tick();

    // reset during WAIT of a DMA read
    do_single(1, 0, 13'h00B, 32'h0, lat, rd);
    chk("pre_abort_rdata", dma_rdata, 32'h21);
    dma_we = 0; dma_addr = 13'h00C; dma_req = 1;
    tick();
    chk("abort_busy_grant", {31'd0, busy}, 1);
    dma_req = 0;
    tick();
    rst = 0;
    tick();
    rst = 1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_rdata", dma_rdata, 0);
    chk("abort_ack", {31'd0, dma_ack}, 0);
    for (int n = 0; n < 6; n++) begin
      tick();
      chk("abort_no_ack", {31'd0, dma_ack}, 0);
    end
    do_single(1, 0, 13'h00C, 32'h0, lat, rd);
    chk("reissue_lat", lat, 3);
    chk("reissue_rdata", rd, 32'h24);

    // CPU drops req the cycle after grant
    cpu_we = 0; cpu_addr = 13'h010; cpu_req = 1;
    tick();
    cpu_req = 0;
    lat = -1;
    for (int n = 2; n <= 12; n++) begin
      tick();
      if (cpu_ack) begin lat = n; rd = cpu_rdata; break; end
    end
    chk("drop_lat", lat, 3);
    chk("drop_rdata", rd, 32'h12345678);
    tick();
    chk("drop_busy0", {31'd0, busy}, 0);
    tick();
    chk("drop_busy1", {31'd0, busy}, 0);

    // RD_LAT = 3 instance
    d3_dma_req = 1; d3_dma_we = 1; d3_dma_addr = 13'h020; d3_dma_wdata = 32'hCAFEF00D;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin tick(); if (d3_dma_ack) begin lat = n; break; end end
    d3_dma_req = 0;
    chk("lat3_write_lat", lat, 2);
    tick();
    d3_dma_req = 1; d3_dma_we = 0;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin tick(); if (d3_dma_ack) begin lat = n; break; end end
    d3_dma_req = 0;
    chk("lat3_read_lat", lat, 5);
    chk("lat3_read_rdata", d3_dma_rdata, 32'hCAFEF00D);
    tick();
    chk("lat3_busy", {31'd0, d3_busy}, 0);
    chk("lat3_cpu_idle", {d3_cpu_rdata[30:0], d3_cpu_ack | d3_cpu_stall}, 0);

    // randomized run against a transaction-level model
    do_reset();
    for (int i = 0; i < 32; i++) ref_ok[i] = 0;
    begin
      int          e, free_edge, ack_edge, streak, idx;
      bit          pending, w_dma, w_we, w_ok, is_ack;
      logic [31:0] w_exp;
      bit          c_act, d_act;
      e = 0; free_edge = 0; ack_edge = 0; streak = 0; pending = 0;
      w_dma = 0; w_we = 0; w_ok = 0; w_exp = 0; c_act = 0; d_act = 0;
      for (int cyc = 0; cyc < 1500; cyc++) begin
        @(posedge clk);
        e++;
        if (!pending && e >= free_edge && (cpu_req || dma_req)) begin
          w_dma = dma_req && (!cpu_req || streak == MAXB);
          if (w_dma || !dma_req) streak = 0;
          else if (streak < MAXB) streak = streak + 1;
          w_we = w_dma ? dma_we : cpu_we;
          idx  = int'((w_dma ? dma_addr : cpu_addr) - 13'h100);
          if (w_we) begin
            ref_mem[idx] = w_dma ? dma_wdata : cpu_wdata;
            ref_ok[idx]  = 1;
            ack_edge = e + 1;
          end else begin
            w_exp = ref_mem[idx];
            w_ok  = ref_ok[idx];
            ack_edge = e + 1 + RD_LAT;
          end
          pending = 1;
        end
        #1;
        is_ack = pending && (e == ack_edge);
        chk("rnd_cpu_ack", {31'd0, cpu_ack}, {31'd0, is_ack && !w_dma});
        chk("rnd_dma_ack", {31'd0, dma_ack}, {31'd0, is_ack && w_dma});
        chk("rnd_busy", {31'd0, busy}, {31'd0, pending});
        chk("rnd_stall", {31'd0, cpu_stall}, {31'd0, cpu_req && !(is_ack && !w_dma)});
        if (is_ack && !w_we && w_ok) chk("rnd_rdata", w_dma ? dma_rdata : cpu_rdata, w_exp);
        if (is_ack) begin
          pending = 0;
          free_edge = e + 2;
          if (w_dma) d_act = 0; else c_act = 0;
        end
        if (!c_act) begin
          cpu_req = 0;
          if ($urandom_range(2) == 0) begin
            c_act = 1; cpu_req = 1; cpu_we = 1'($urandom_range(1));
            cpu_addr = 13'h100 + 13'($urandom_range(31)); cpu_wdata = $urandom;
          end
        end
        if (!d_act) begin
          dma_req = 0;
          if ($urandom_range(2) == 0) begin
            d_act = 1; dma_req = 1; dma_we = 1'($urandom_range(1));
            dma_addr = 13'h100 + 13'($urandom_range(31)); dma_wdata = $urandom;
          end
        end
      end
    end
    idle_inputs();
    tick(); tick(); tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
